// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// instruction field positions and the fetch FSM state type.
package fetch_pkg;

  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_BR  = 4'b1100;

  // Field positions inside a 16-bit instruction word.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 8;

  // Width of the slice of the instruction that fetch needs to look at.
  localparam int HI_W = OPC_MSB - TGT_LSB + 1;

  typedef enum logic {
    FETCH   = 1'b0,
    WAIT_BR = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode for fetch: classifies the instruction coming back
// from ROM and supplies the two candidate next-PC values.
// Only the opcode and target fields are inspected, so only that upper slice
// of the instruction word is brought in.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [HI_W-1:0] rom_hi,
  input  logic [3:0]      pc,
  output logic            is_jmp,
  output logic            is_br,
  output logic [3:0]      target,
  output logic [3:0]      pc_inc
);

  logic [3:0] opcode;

  // Slice the fields relative to the bottom of the upper slice.
  assign opcode = rom_hi[OPC_MSB-TGT_LSB:OPC_LSB-TGT_LSB];
  assign target = rom_hi[TGT_MSB-TGT_LSB:0];
  assign is_jmp = (opcode == OP_JMP);
  assign is_br  = (opcode == OP_BR);
  // 4-bit add wraps 15 back to 0 naturally.
  assign pc_inc = pc + 4'd1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address, and holds a
// one-entry instruction register handed to decode over valid/ready.
// jmp and br are resolved here; br waits for execute to go idle so the zero
// flag is architectural before choosing the next PC.
// Optional feature macro: FETCH_JMP_FOLD_EN (fold jmp out of the decode stream).
//
// Handshake: decode owns ir_ready; an entry transfers on any rising edge where
// ir_valid && ir_ready. While ir_valid=1 and ir_ready=0, ir_data/ir_pc hold.
// A new entry may be loaded on the same edge the old one transfers.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] ir_data,
  output logic [3:0]  ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        exec_idle,
  input  logic        zero_flag,
  output logic        br_wait
);

  fetch_state_e state;
  logic [3:0]   pc;
  logic         slot_free;
  logic         is_jmp;
  logic         is_br;
  logic [3:0]   target;
  logic [3:0]   pc_inc;

  fetch_predecode u_predecode (
    .rom_hi (rom_data[OPC_MSB:TGT_LSB]),
    .pc     (pc),
    .is_jmp (is_jmp),
    .is_br  (is_br),
    .target (target),
    .pc_inc (pc_inc)
  );

  assign rom_addr  = pc;
  assign slot_free = !ir_valid || ir_ready;
  // Directly decoded from the state register, so glitch-free.
  assign br_wait   = (state == WAIT_BR);

  // Fetch FSM, PC and instruction register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir_data  <= 16'h0000;
      ir_pc    <= 4'h0;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (slot_free) begin
            if (is_br) begin
              // Park on the br; its target is re-read from ROM on resolution.
              state    <= WAIT_BR;
              ir_valid <= 1'b0;
            end else if (is_jmp) begin
              pc <= target;
`ifdef FETCH_JMP_FOLD_EN
              ir_valid <= 1'b0;
`else
              ir_data  <= rom_data;
              ir_pc    <= pc;
              ir_valid <= 1'b1;
`endif
            end else begin
              ir_data  <= rom_data;
              ir_pc    <= pc;
              ir_valid <= 1'b1;
              pc       <= pc_inc;
            end
          end
        end
        WAIT_BR: begin
          if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
          end
          if (!ir_valid && exec_idle) begin
            pc    <= zero_flag ? target : pc_inc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run
// against a program-walking reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ir_data;
  logic [3:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        exec_idle;
  logic        zero_flag;
  logic        br_wait;

  logic [15:0] rom [16];
  bit          taken_map [16];
  logic [3:0]  m_pc;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ir_data   (ir_data),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .exec_idle (exec_idle),
    .zero_flag (zero_flag),
    .br_wait   (br_wait)
  );

  // Combinational program ROM.
  assign rom_data = rom[rom_addr];

  // Clock generation.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  // Two reset cycles, then release; no edge has happened since release.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Walks the program from m_pc until the next instruction decode should see.
  function automatic void model_next(output logic [15:0] d, output logic [3:0] p, output bit ok);
    logic [15:0] w;
    ok = 1'b0;
    d  = 16'h0000;
    p  = 4'h0;
    for (int s = 0; s < 64 && !ok; s++) begin
      w = rom[m_pc];
      case (w[15:12])
        4'b1000: begin
`ifndef FETCH_JMP_FOLD_EN
          d  = w;
          p  = m_pc;
          ok = 1'b1;
`endif
          m_pc = w[11:8];
        end
        4'b1100: m_pc = taken_map[m_pc] ? w[11:8] : m_pc + 4'd1;
        default: begin
          d    = w;
          p    = m_pc;
          ok   = 1'b1;
          m_pc = m_pc + 4'd1;
        end
      endcase
    end
  endfunction

  // Branch at 4 with execute busy two cycles, then resolving with 'taken'.
  task automatic run_branch(input bit taken, input logic [3:0] exp_pc, input logic [15:0] exp_data);
    int bw;
    clear_rom();
    rom[0]  = 16'h8400;
    rom[4]  = 16'hCA00;
    rom[5]  = 16'h5000;
    rom[10] = 16'hF200;
    ir_ready  = 1'b1;
    exec_idle = 1'b0;
    zero_flag = !taken;
    do_reset();
    tick();
    tick();
    check("br_enter_addr", 16'(rom_addr), 16'h4);
    check("br_enter_valid", 16'(ir_valid), 16'h0);
    bw = 0;
    for (int i = 0; i < 3; i++) begin
      if (br_wait) bw++;
      exec_idle = (i == 2);
      zero_flag = (i == 2) ? taken : ((i == 0) ? !taken : taken);
      tick();
    end
    check("br_wait_cycles", 16'(bw), 16'd3);
    check("br_wait_clear", 16'(br_wait), 16'h0);
    check("br_next_pc", 16'(rom_addr), 16'(exp_pc));
    tick();
    check("br_after_data", ir_data, exp_data);
    check("br_after_pc", 16'(ir_pc), 16'(exp_pc));
  endtask

  initial begin
    logic [15:0] ed;
    logic [3:0]  ep;
    bit          ok;
    logic        prev_valid;
    logic        prev_ready;
    logic [15:0] prev_data;
    logic [3:0]  prev_pc;
    int          hs;
    int          k;
    logic [3:0]  opc;

    rst_n     = 1'b0;
    ir_ready  = 1'b1;
    exec_idle = 1'b1;
    zero_flag = 1'b0;

    // Straight-line start-up and reset values.
    clear_rom();
    rom[0] = 16'h1201;
    rom[1] = 16'hB401;
    rom[2] = 16'h2000;
    do_reset();
    check("rst_valid", 16'(ir_valid), 16'h0);
    check("rst_data", ir_data, 16'h0000);
    check("rst_ir_pc", 16'(ir_pc), 16'h0);
    check("rst_addr", 16'(rom_addr), 16'h0);
    check("rst_br_wait", 16'(br_wait), 16'h0);
    tick();
    check("first_valid", 16'(ir_valid), 16'h1);
    check("first_pc", 16'(ir_pc), 16'h0);
    check("first_data", ir_data, 16'h1201);
    check("first_addr", 16'(rom_addr), 16'h1);
    tick();
    check("second_pc", 16'(ir_pc), 16'h1);
    check("second_data", ir_data, 16'hB401);

    // Backpressure: entry and PC hold while decode stalls.
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_data", ir_data, 16'hB401);
      check("stall_pc", 16'(ir_pc), 16'h1);
      check("stall_addr", 16'(rom_addr), 16'h2);
    end
    ir_ready = 1'b1;
    tick();
    check("resume_pc", 16'(ir_pc), 16'h2);
    check("resume_data", ir_data, 16'h2000);

    // Loop 6: out r7, 7: jmp 3.
    clear_rom();
    rom[0] = 16'h8600;
    rom[3] = 16'h3300;
    rom[6] = 16'hE700;
    rom[7] = 16'h8300;
    do_reset();
    tick();
    tick();
    check("loop_pc6", 16'(ir_pc), 16'h6);
    check("loop_addr7", 16'(rom_addr), 16'h7);
    tick();
    check("jmp_target", 16'(rom_addr), 16'h3);
`ifdef FETCH_JMP_FOLD_EN
    check("jmp_folded", 16'(ir_valid), 16'h0);
`else
    check("jmp_valid", 16'(ir_valid), 16'h1);
    check("jmp_data", ir_data, 16'h8300);
    check("jmp_pc", 16'(ir_pc), 16'h7);
`endif
    tick();
    check("after_jmp_pc", 16'(ir_pc), 16'h3);
    check("after_jmp_data", ir_data, 16'h3300);

    // Branch taken and not taken.
    run_branch(1'b1, 4'd10, 16'hF200);
    run_branch(1'b0, 4'd5, 16'h5000);

    // PC wrap from 15 to 0.
    clear_rom();
    rom[0]    = 16'h8F00;
    rom[15]   = 16'h4F00;
    exec_idle = 1'b1;
    do_reset();
    tick();
    tick();
    check("wrap_pc15", 16'(ir_pc), 16'hF);
    check("wrap_addr", 16'(rom_addr), 16'h0);

    // Reset while waiting on a branch.
    clear_rom();
    rom[0]    = 16'hC500;
    exec_idle = 1'b0;
    do_reset();
    tick();
    check("mid_br_wait", 16'(br_wait), 16'h1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_br_wait", 16'(br_wait), 16'h0);
    check("mid_rst_addr", 16'(rom_addr), 16'h0);
    check("mid_rst_valid", 16'(ir_valid), 16'h0);
    rst_n = 1'b1;

    // Randomized program against the program-walking model.
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 9);
      taken_map[i] = 1'($urandom_range(0, 1));
      if (k == 0) rom[i] = {4'b1000, 4'($urandom_range(0, 15)), 8'($urandom)};
      else if (k == 1) rom[i] = {4'b1100, 4'($urandom_range(0, 15)), 8'($urandom)};
      else begin
        opc = 4'($urandom_range(0, 15));
        if (opc == 4'b1000 || opc == 4'b1100) opc = 4'b0001;
        rom[i] = {opc, 12'($urandom)};
      end
    end
    ir_ready  = 1'b0;
    exec_idle = 1'b1;
    do_reset();
    m_pc       = 4'd0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = 16'h0000;
    prev_pc    = 4'h0;
    hs         = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 16'(ir_valid), 16'h1);
        check("hold_data", ir_data, prev_data);
        check("hold_pc", 16'(ir_pc), 16'(prev_pc));
      end
      ir_ready  = ($urandom_range(0, 3) != 0);
      exec_idle = ($urandom_range(0, 2) == 0);
      zero_flag = exec_idle ? taken_map[rom_addr] : 1'($urandom_range(0, 1));
      if (ir_valid && ir_ready) begin
        model_next(ed, ep, ok);
        hs++;
        check("rand_expected", 16'(ok), 16'h1);
        check("rand_data", ir_data, ed);
        check("rand_pc", 16'(ir_pc), 16'(ep));
      end
      prev_valid = ir_valid;
      prev_ready = ir_ready;
      prev_data  = ir_data;
      prev_pc    = ir_pc;
    end
    // Drain cycle so the final handshake completes before reporting.
    tick();
    check("rand_activity", 16'(hs > 0), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
